// File: rtl/hpdcache_cmo_arbiter.sv
// Round-robin arbiter sharing one CMO handler among N_REQ requesters.
// One request is outstanding at a time. Completion is seen when the handler returns to ready.
module hpdcache_cmo_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int OP_WIDTH   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*OP_WIDTH-1:0]      req_op_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [N_REQ-1:0]               rsp_valid_o,
    output logic                           rsp_error_o,
    output logic                           cmoh_req_valid_o,
    input  logic                           cmoh_req_ready_i,
    output logic [OP_WIDTH-1:0]            cmoh_req_op_o,
    output logic [ADDR_WIDTH-1:0]          cmoh_req_addr_o,
    output logic [DATA_WIDTH-1:0]          cmoh_req_wdata_o,
    output logic                           busy_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic                    any_valid;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        scan_idx;
    logic [OP_WIDTH-1:0]     sel_op;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!any_valid && req_valid_i[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_op    = req_op_i[i*OP_WIDTH +: OP_WIDTH];
                sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d  = winner;
                    op_d     = sel_op;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
                    // Malformed ops are answered with an error and never reach the handler.
                    state_d  = $onehot(sel_op) ? ISSUE : ERR;
                end
            end
            ISSUE: if (cmoh_req_ready_i) state_d = WAIT;
            WAIT:  if (cmoh_req_ready_i) state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o      = '0;
        rsp_valid_o      = '0;
        rsp_error_o      = 1'b0;
        cmoh_req_valid_o = 1'b0;
        case (state_q)
            IDLE:  if (any_valid) req_ready_o[winner] = 1'b1;
            ISSUE: cmoh_req_valid_o = 1'b1;
            WAIT:  if (cmoh_req_ready_i) rsp_valid_o[owner_q] = 1'b1;
            ERR: begin
                rsp_valid_o[owner_q] = 1'b1;
                rsp_error_o          = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmoh_req_op_o    = op_q;
    assign cmoh_req_addr_o  = addr_q;
    assign cmoh_req_wdata_o = wdata_q;
    assign busy_o           = (state_q != IDLE);

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));
    a_rsp_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_valid_o));
    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cmoh_req_valid_o && !cmoh_req_ready_i) |=>
        (cmoh_req_valid_o && $stable(cmoh_req_op_o) && $stable(cmoh_req_addr_o)
         && $stable(cmoh_req_wdata_o)));
`endif

endmodule

// File: tb/tb_hpdcache_cmo_arbiter.sv
// Bench for hpdcache_cmo_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_hpdcache_cmo_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int OW = 4;
    localparam logic [N-1:0] ONE = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N*OW-1:0]     req_op = '0;
    logic [N*AW-1:0]     req_addr = '0;
    logic [N*DW-1:0]     req_wdata = '0;
    logic                cmoh_ready = 1'b1;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic                rsp_error;
    logic                cmoh_valid;
    logic [OW-1:0]       cmoh_op;
    logic [AW-1:0]       cmoh_addr;
    logic [DW-1:0]       cmoh_wdata;
    logic                busy;

    hpdcache_cmo_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_WIDTH(OW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i(req_op),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_error_o(rsp_error),
        .cmoh_req_valid_o(cmoh_valid),
        .cmoh_req_ready_i(cmoh_ready),
        .cmoh_req_op_o(cmoh_op),
        .cmoh_req_addr_o(cmoh_addr),
        .cmoh_req_wdata_o(cmoh_wdata),
        .busy_o(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] grant_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        cmoh_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_op[i*OW +: OW]    = op;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // ---------------- reference model ----------------
    // A transaction is either absent, waiting to be handed over, handed over and
    // awaiting completion, or rejected as malformed.
    bit             m_busy = 0;
    bit             m_fwd  = 0;
    bit             m_err  = 0;
    int             m_owner = 0;
    int             m_ptr  = 0;
    logic [OW-1:0]  m_op;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        logic         e_err;
        logic         e_cval;
        int           w;
        if (!rst_n) begin
            m_busy = 0; m_fwd = 0; m_err = 0; m_ptr = 0;
            check("rst_ready", req_ready, 0);
            check("rst_rsp", rsp_valid, 0);
            check("rst_err", rsp_error, 0);
            check("rst_cval", cmoh_valid, 0);
            check("rst_busy", busy, 0);
        end else begin
            e_ready = '0; e_rsp = '0; e_err = 0; e_cval = 0;
            w = rr_pick(req_valid, m_ptr);
            if (!m_busy) begin
                if (w >= 0) e_ready = ONE << w;
            end else if (m_err) begin
                e_rsp = ONE << m_owner;
                e_err = 1;
            end else if (!m_fwd) begin
                e_cval = 1;
            end else if (cmoh_ready) begin
                e_rsp = ONE << m_owner;
            end
            check("m_ready", req_ready, e_ready);
            check("m_rsp", rsp_valid, e_rsp);
            check("m_err", rsp_error, e_err);
            check("m_cval", cmoh_valid, e_cval);
            check("m_busy", busy, m_busy);
            if (e_cval) begin
                check("m_op", cmoh_op, m_op);
                check("m_addr", cmoh_addr, m_addr);
                check("m_wdata", cmoh_wdata, m_wdata);
            end
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy  = 1;
                    m_fwd   = 0;
                    m_owner = w;
                    m_op    = req_op[w*OW +: OW];
                    m_addr  = req_addr[w*AW +: AW];
                    m_wdata = req_wdata[w*DW +: DW];
                    m_err   = ($countones(m_op) != 1);
                    m_ptr   = (w + 1) % N;
                end
            end else if (m_err) begin
                m_busy = 0;
            end else if (!m_fwd) begin
                if (cmoh_ready) m_fwd = 1;
            end else if (cmoh_ready) begin
                m_busy = 0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n_rsp;

        // Single fence, handler always ready.
        do_reset();
        set_req(0, 4'b0001, 64'h1000, 64'h0);
        cmoh_ready = 1'b1;
        at_neg();
        check("t1_ready_c0", req_ready, 4'b0001);
        check("t1_cval_c0", cmoh_valid, 0);
        step();
        req_valid = '0;
        at_neg();
        check("t1_cval_c1", cmoh_valid, 1);
        check("t1_ready_c1", req_ready, 0);
        check("t1_rsp_c1", rsp_valid, 0);
        step();
        at_neg();
        check("t1_rsp_c2", rsp_valid, 4'b0001);
        check("t1_err_c2", rsp_error, 0);
        step();
        at_neg();
        check("t1_busy_c3", busy, 0);

        // All requesters valid: strict rotation 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'b0001, {$urandom, $urandom}, {$urandom, $urandom});
        cmoh_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            grant_q.push_back(ONE << (k % N));
            exp_q.push_back(ONE << (k % N));
        end
        n_rsp = 0;
        for (int c = 0; c < 60 && n_rsp < 8; c++) begin
            at_neg();
            if (req_ready != 0)
                check("t2_grant", req_ready, (grant_q.size() > 0) ? grant_q.pop_front() : '0);
            if (rsp_valid != 0) begin
                check("t2_rsp", rsp_valid, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
                n_rsp++;
            end
            step();
            if (n_rsp == 8) req_valid = '0;
        end
        req_valid = '0;
        check("t2_rsp_count", n_rsp, 8);
        check("t2_grants_left", grant_q.size(), 0);

        // Long inval_all on req2 while others wait.
        do_reset();
        set_req(2, 4'b1000, 64'h2000, 64'hF);
        cmoh_ready = 1'b1;
        at_neg();
        check("t3_ready_c0", req_ready, 4'b0100);
        step();
        req_valid = '0;
        set_req(0, 4'b0001, 64'h10, 64'h0);
        set_req(1, 4'b0001, 64'h20, 64'h0);
        set_req(3, 4'b0001, 64'h30, 64'h0);
        at_neg();
        check("t3_cval_c1", cmoh_valid, 1);
        step();
        cmoh_ready = 1'b0;
        for (int i = 0; i < 130; i++) begin
            at_neg();
            check("t3_no_grant", req_ready, 0);
            check("t3_no_rsp", rsp_valid, 0);
            step();
        end
        cmoh_ready = 1'b1;
        at_neg();
        check("t3_rsp", rsp_valid, 4'b0100);
        check("t3_err", rsp_error, 0);
        step();
        req_valid = '0;
        at_neg();
        check("t3_busy_after", busy, 0);

        // Malformed op on req1.
        do_reset();
        set_req(1, 4'b0110, 64'h40, 64'h0);
        at_neg();
        check("t4_ready_c0", req_ready, 4'b0010);
        step();
        req_valid = '0;
        at_neg();
        check("t4_cval_c1", cmoh_valid, 0);
        check("t4_rsp_c1", rsp_valid, 4'b0010);
        check("t4_err_c1", rsp_error, 1);
        step();
        at_neg();
        check("t4_busy_c2", busy, 0);
        check("t4_rsp_c2", rsp_valid, 0);
        check("t4_cval_c2", cmoh_valid, 0);

        // Handler back-pressure during ISSUE.
        do_reset();
        set_req(0, 4'b0010, 64'h8000_0040, 64'h3);
        cmoh_ready = 1'b0;
        at_neg();
        check("t5_ready_c0", req_ready, 4'b0001);
        step();
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("t5_cval_hold", cmoh_valid, 1);
            check("t5_addr_hold", cmoh_addr, 64'h8000_0040);
            step();
        end
        cmoh_ready = 1'b1;
        at_neg();
        check("t5_cval_c6", cmoh_valid, 1);
        check("t5_addr_c6", cmoh_addr, 64'h8000_0040);
        check("t5_op_c6", cmoh_op, 4'b0010);
        step();
        at_neg();
        check("t5_rsp_c7", rsp_valid, 4'b0001);
        check("t5_cval_c7", cmoh_valid, 0);
        step();

        // Reset while waiting for completion.
        do_reset();
        set_req(0, 4'b0001, 64'h50, 64'h0);
        cmoh_ready = 1'b1;
        at_neg();
        step();
        req_valid = '0;
        at_neg();
        step();
        cmoh_ready = 1'b0;
        at_neg();
        check("t6_busy_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy_rst", busy, 0);
        check("t6_rsp_rst", rsp_valid, 0);
        cmoh_ready = 1'b1;
        step();
        at_neg();
        check("t6_rsp_in_rst", rsp_valid, 0);
        step();
        rst_n = 1'b1;
        set_req(3, 4'b0001, 64'h60, 64'h0);
        at_neg();
        check("t6_ready_r3", req_ready, 4'b1000);
        step();
        req_valid = '0;
        at_neg();
        check("t6_cval_r3", cmoh_valid, 1);
        step();
        at_neg();
        check("t6_rsp_r3", rsp_valid, 4'b1000);
        step();

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [OW-1:0] op;
                if ($urandom_range(0, 9) == 0) op = OW'($urandom_range(0, 15));
                else op = OW'(1) << $urandom_range(0, OW - 1);
                req_valid[i]          = ($urandom_range(0, 99) < 40);
                req_op[i*OW +: OW]    = op;
                req_addr[i*AW +: AW]  = {$urandom, $urandom};
                req_wdata[i*DW +: DW] = {$urandom, $urandom};
            end
            cmoh_ready = ($urandom_range(0, 99) < 65);
            step();
        end
        req_valid = '0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
